pc_flow_ctrl: RTL and testbench
===============================

Name: pc_flow_ctrl

Overview:
- Sequencing controller that drives the 3-bit PC-source select and the PC/EPC write strobes of the multicycle datapath.
- Decides, per instruction, whether the PC takes:
  - PC+4 or the jr target (ALU result),
  - the branch target (ALU out register),
  - the jump target (shift 26->28),
  - EPC,
  - or an exception vector read into MDR.
- Runs the multi-cycle exception entry: save EPC, read the vector from memory, load the PC.

Parameters:
- MEM_WAIT, 1, extra cycles vec_read is held before MDR is valid (0..15).
- VEC_OPCODE, 8'd253, byte address of the invalid-opcode handler vector.
- VEC_OVF, 8'd254, byte address of the overflow handler vector.
- VEC_DIV0, 8'd255, byte address of the divide-by-zero handler vector.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- fetch  input  1  one-cycle pulse in the fetch cycle; requests PC <= PC+4.
- resolve  input  1  one-cycle pulse when decode/execute results are valid.
- op_beq  input  1  current instruction is beq.
- op_bne  input  1  current instruction is bne.
- op_j  input  1  current instruction is j or jal.
- op_jr  input  1  current instruction is jr (ALU passes rs).
- op_rte  input  1  current instruction is rte.
- alu_zero  input  1  ALU zero flag.
- exc_opcode  input  1  invalid-opcode exception.
- exc_ovf  input  1  overflow exception.
- exc_div0  input  1  divide-by-zero exception.
- pc_src  output  3  PC source select.
- pc_write  output  1  PC load strobe.
- epc_write  output  1  EPC load strobe.
- vec_read  output  1  memory read request for the vector.
- vec_addr  output  8  vector byte address.
- exc_cause  output  2  last exception cause: 00 none, 01 opcode, 10 overflow, 11 div0.
- busy  output  1  high in every state except IDLE.

Behaviour:
- pc_src encoding:
  - 000 ALU out (branch target)
  - 001 ALU result (PC+4 / jr)
  - 010 jump target
  - 011 EPC
  - 100 MDR (vector)
  - 101..111 never driven.
- Moore FSM. All outputs are decoded from the state register plus registered vec_addr and exc_cause; no input-to-output combinational path.
- Reset (asynchronous, reset_n low):
  - state IDLE, counter 0, pc_src=001;
  - pc_write, epc_write, vec_read, busy = 0;
  - vec_addr=0, exc_cause=00.
  - Reset mid-sequence abandons the sequence; no further strobes are issued.
- IDLE: pc_src=001, no strobes.
  - resolve has priority over fetch if both are high; fetch is then dropped.
  - fetch (no resolve) -> INC.
  - resolve selects one state by priority: any exc_* -> EXC_SAVE; op_rte -> RTE; op_jr -> JR; op_j -> JMP; (op_beq & alu_zero) | (op_bne & ~alu_zero) -> BR.
  - resolve with none of the above (e.g. branch not taken) stays IDLE with no pc_write.
- Single-cycle states, each returning to IDLE. Resolve/fetch at edge N gives the pc_write pulse in cycle N+1:
  - INC: pc_src=001, pc_write=1.
  - JR: pc_src=001, pc_write=1.
  - BR: pc_src=000, pc_write=1.
  - JMP: pc_src=010, pc_write=1.
  - RTE: pc_src=011, pc_write=1.
- Exception entry:
  - On resolve, vec_addr and exc_cause are latched. Cause priority: opcode > div0 > ovf.
  - EXC_SAVE: epc_write=1 for one cycle; counter <= MEM_WAIT; -> EXC_READ.
  - EXC_READ: vec_read=1. If counter==0 -> EXC_LOAD, else decrement. Lasts MEM_WAIT+1 cycles.
  - EXC_LOAD: pc_src=100, pc_write=1 -> IDLE.
  - vec_addr stays stable from EXC_SAVE through EXC_LOAD.
  - exc_cause holds until the next exception or reset.
- While busy, fetch and resolve are ignored (protocol error, not queued).
- epc_write and pc_write are never high in the same cycle.

Decomposition:
- Shared package holds:
  - PC_SRC_ALUOUT/ALURES/JUMP/EPC/MDR (3-bit);
  - CAUSE_* (2-bit);
  - state enum;
  - default vector addresses.
- No sub-module. The wait counter is inline; a separate counter module is not warranted.

Test Plan:
- reset_n low mid-EXC_READ -> next cycle: state IDLE, pc_src=001, all strobes 0, exc_cause=00.
- fetch pulse at cycle 0 -> cycle 1: pc_write=1, pc_src=001; cycle 2: pc_write=0, busy=0.
- resolve with op_beq=1, alu_zero=1 -> pc_src=000 pc_write one cycle. Same with alu_zero=0 -> no pc_write, busy stays 0.
- resolve with op_j=1 and op_rte=1 -> pc_src=011 (RTE wins). With op_jr only -> pc_src=001 pulse.
- MEM_WAIT=1, resolve with exc_ovf=1 and exc_div0=1:
  - cycle 1: epc_write;
  - cycles 2-3: vec_read, vec_addr=255;
  - cycle 4: pc_src=100, pc_write;
  - exc_cause=11.
- Exception sequence in progress with fetch/resolve pulsed in EXC_READ -> ignored; exactly one pc_write occurs (at EXC_LOAD).

Source files
------------

// File: rtl/pc_flow_ctrl_pkg.sv
// Shared encodings for the PC sequencing controller: PC source selects,
// exception cause codes, FSM states and default handler vector addresses.
package pc_flow_ctrl_pkg;

    localparam logic [2:0] PC_SRC_ALUOUT = 3'b000;
    localparam logic [2:0] PC_SRC_ALURES = 3'b001;
    localparam logic [2:0] PC_SRC_JUMP   = 3'b010;
    localparam logic [2:0] PC_SRC_EPC    = 3'b011;
    localparam logic [2:0] PC_SRC_MDR    = 3'b100;

    localparam logic [1:0] CAUSE_NONE   = 2'b00;
    localparam logic [1:0] CAUSE_OPCODE = 2'b01;
    localparam logic [1:0] CAUSE_OVF    = 2'b10;
    localparam logic [1:0] CAUSE_DIV0   = 2'b11;

    localparam logic [7:0] VEC_OPCODE_DEFAULT = 8'd253;
    localparam logic [7:0] VEC_OVF_DEFAULT    = 8'd254;
    localparam logic [7:0] VEC_DIV0_DEFAULT   = 8'd255;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INC,
        ST_JR,
        ST_BR,
        ST_JMP,
        ST_RTE,
        ST_EXC_SAVE,
        ST_EXC_READ,
        ST_EXC_LOAD
    } state_e;

endpackage

// File: rtl/pc_flow_ctrl.sv
// Moore sequencer for the multicycle PC: picks the PC source per instruction
// and runs the save-EPC / read-vector / load-PC exception entry.
module pc_flow_ctrl
    import pc_flow_ctrl_pkg::*;
#(
    parameter int         MEM_WAIT   = 1,
    parameter logic [7:0] VEC_OPCODE = VEC_OPCODE_DEFAULT,
    parameter logic [7:0] VEC_OVF    = VEC_OVF_DEFAULT,
    parameter logic [7:0] VEC_DIV0   = VEC_DIV0_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       fetch,
    input  logic       resolve,
    input  logic       op_beq,
    input  logic       op_bne,
    input  logic       op_j,
    input  logic       op_jr,
    input  logic       op_rte,
    input  logic       alu_zero,
    input  logic       exc_opcode,
    input  logic       exc_ovf,
    input  logic       exc_div0,
    output logic [2:0] pc_src,
    output logic       pc_write,
    output logic       epc_write,
    output logic       vec_read,
    output logic [7:0] vec_addr,
    output logic [1:0] exc_cause,
    output logic       busy
);

    state_e     r_state;
    state_e     w_next;
    logic [3:0] r_cnt;
    logic [7:0] r_vec_addr;
    logic [1:0] r_exc_cause;
    logic       w_exc;
    logic       w_br_taken;
    logic       w_take_exc;

    assign w_exc      = exc_opcode | exc_ovf | exc_div0;
    assign w_br_taken = (op_beq & alu_zero) | (op_bne & ~alu_zero);
    assign w_take_exc = (r_state == ST_IDLE) & resolve & w_exc;

    // Requests only count in IDLE; anything arriving while busy is dropped.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (resolve) begin
                    if (w_exc)           w_next = ST_EXC_SAVE;
                    else if (op_rte)     w_next = ST_RTE;
                    else if (op_jr)      w_next = ST_JR;
                    else if (op_j)       w_next = ST_JMP;
                    else if (w_br_taken) w_next = ST_BR;
                end else if (fetch) begin
                    w_next = ST_INC;
                end
            end
            ST_EXC_SAVE: w_next = ST_EXC_READ;
            ST_EXC_READ: if (r_cnt == 4'd0) w_next = ST_EXC_LOAD;
            default:     w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        pc_src    = PC_SRC_ALURES;
        pc_write  = 1'b0;
        epc_write = 1'b0;
        vec_read  = 1'b0;
        busy      = (r_state != ST_IDLE);
        case (r_state)
            ST_INC, ST_JR: pc_write = 1'b1;
            ST_BR:  begin pc_src = PC_SRC_ALUOUT; pc_write = 1'b1; end
            ST_JMP: begin pc_src = PC_SRC_JUMP;   pc_write = 1'b1; end
            ST_RTE: begin pc_src = PC_SRC_EPC;    pc_write = 1'b1; end
            ST_EXC_SAVE: epc_write = 1'b1;
            ST_EXC_READ: vec_read  = 1'b1;
            ST_EXC_LOAD: begin pc_src = PC_SRC_MDR; pc_write = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_vec_addr  <= 8'd0;
            r_exc_cause <= CAUSE_NONE;
        end else begin
            r_state <= w_next;
            if (r_state == ST_EXC_SAVE)
                r_cnt <= 4'(MEM_WAIT);
            else if (r_state == ST_EXC_READ && r_cnt != 4'd0)
                r_cnt <= r_cnt - 4'd1;
            // Cause priority: opcode > div0 > ovf.
            if (w_take_exc) begin
                if (exc_opcode) begin
                    r_vec_addr  <= VEC_OPCODE;
                    r_exc_cause <= CAUSE_OPCODE;
                end else if (exc_div0) begin
                    r_vec_addr  <= VEC_DIV0;
                    r_exc_cause <= CAUSE_DIV0;
                end else begin
                    r_vec_addr  <= VEC_OVF;
                    r_exc_cause <= CAUSE_OVF;
                end
            end
        end
    end

    assign vec_addr  = r_vec_addr;
    assign exc_cause = r_exc_cause;

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Directed bench for pc_flow_ctrl with hand-computed expected outputs.
module tb_pc_flow_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       fetch, resolve, op_beq, op_bne, op_j, op_jr, op_rte, alu_zero;
    logic       exc_opcode, exc_ovf, exc_div0;
    logic [2:0] pc_src;
    logic       pc_write, epc_write, vec_read, busy;
    logic [7:0] vec_addr;
    logic [1:0] exc_cause;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pcw;

    pc_flow_ctrl #(.MEM_WAIT(1)) dut (
        .clk(clk), .reset_n(reset_n), .fetch(fetch), .resolve(resolve),
        .op_beq(op_beq), .op_bne(op_bne), .op_j(op_j), .op_jr(op_jr),
        .op_rte(op_rte), .alu_zero(alu_zero), .exc_opcode(exc_opcode),
        .exc_ovf(exc_ovf), .exc_div0(exc_div0), .pc_src(pc_src),
        .pc_write(pc_write), .epc_write(epc_write), .vec_read(vec_read),
        .vec_addr(vec_addr), .exc_cause(exc_cause), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        fetch = 0; resolve = 0; op_beq = 0; op_bne = 0; op_j = 0; op_jr = 0;
        op_rte = 0; alu_zero = 0; exc_opcode = 0; exc_ovf = 0; exc_div0 = 0;
    endtask

    // {pc_src, pc_write, epc_write, vec_read, busy}
    function automatic logic [6:0] outs();
        return {pc_src, pc_write, epc_write, vec_read, busy};
    endfunction

    initial begin
        clr_in();
        reset_n = 0;
        #12;
        check("reset_outs", outs(), {3'b001, 4'b0000});
        check("reset_vec", vec_addr, 8'd0);
        check("reset_cause", exc_cause, 2'b00);
        reset_n = 1;
        tick();

        // fetch
        fetch = 1; tick(); clr_in();
        check("fetch_c1", outs(), {3'b001, 4'b1001});
        tick();
        check("fetch_c2", outs(), {3'b001, 4'b0000});

        // beq taken
        resolve = 1; op_beq = 1; alu_zero = 1; tick(); clr_in();
        check("beq_taken", outs(), {3'b000, 4'b1001});
        tick();
        check("beq_after", outs(), {3'b001, 4'b0000});

        // beq not taken
        resolve = 1; op_beq = 1; alu_zero = 0; tick(); clr_in();
        check("beq_not_taken", outs(), {3'b001, 4'b0000});

        // bne taken
        resolve = 1; op_bne = 1; alu_zero = 0; tick(); clr_in();
        check("bne_taken", outs(), {3'b000, 4'b1001});
        tick();

        // rte beats j, resolve beats fetch
        resolve = 1; op_j = 1; op_rte = 1; fetch = 1; tick(); clr_in();
        check("rte_prio", outs(), {3'b011, 4'b1001});
        tick();
        check("fetch_dropped", outs(), {3'b001, 4'b0000});

        resolve = 1; op_jr = 1; tick(); clr_in();
        check("jr", outs(), {3'b001, 4'b1001});
        tick();

        resolve = 1; op_j = 1; tick(); clr_in();
        check("jmp", outs(), {3'b010, 4'b1001});
        tick();

        // exception: div0 beats ovf
        resolve = 1; exc_ovf = 1; exc_div0 = 1; op_j = 1; tick(); clr_in();
        check("exc_c1", outs(), {3'b001, 4'b0101});
        check("exc_c1_vec", vec_addr, 8'd255);
        check("exc_c1_cause", exc_cause, 2'b11);
        tick();
        check("exc_c2", outs(), {3'b001, 4'b0011});
        check("exc_c2_vec", vec_addr, 8'd255);
        tick();
        check("exc_c3", outs(), {3'b001, 4'b0011});
        tick();
        check("exc_c4", outs(), {3'b100, 4'b1001});
        check("exc_c4_vec", vec_addr, 8'd255);
        tick();
        check("exc_c5", outs(), {3'b001, 4'b0000});
        check("exc_cause_hold", exc_cause, 2'b11);

        // opcode exception with requests pulsed while busy
        n_pcw = 0;
        resolve = 1; exc_opcode = 1; exc_ovf = 1; tick(); clr_in();
        check("opc_cause", exc_cause, 2'b01);
        check("opc_vec", vec_addr, 8'd253);
        tick();
        check("opc_read", vec_read, 1'b1);
        fetch = 1; resolve = 1; op_j = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            clr_in();
            if (pc_write) n_pcw++;
        end
        check("busy_ignored_pcw", n_pcw, 1);
        check("busy_ignored_idle", outs(), {3'b001, 4'b0000});

        // reset mid EXC_READ
        resolve = 1; exc_ovf = 1; tick(); clr_in();
        check("ovf_cause", exc_cause, 2'b10);
        check("ovf_vec", vec_addr, 8'd254);
        tick();
        check("mid_read", vec_read, 1'b1);
        reset_n = 0;
        #2;
        check("rst_mid_outs", outs(), {3'b001, 4'b0000});
        check("rst_mid_cause", exc_cause, 2'b00);
        @(negedge clk);
        reset_n = 1;
        n_pcw = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (pc_write | epc_write | vec_read) n_pcw++;
        end
        check("rst_no_strobes", n_pcw, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
